core_run_ctrl: RTL and testbench
================================

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset (0 = reset).
REQ-003 SHALL have port CmdValid, input, 1, command offered this cycle.
REQ-004 SHALL have port CmdReady, output, 1, command accepted when CmdValid && CmdReady.
REQ-005 SHALL have port Cmd, input, 2, command code: 00 NOP, 01 RUN, 10 HALT, 11 STEP.
REQ-006 SHALL have port BpEn, input, 1, breakpoint enable.
REQ-007 SHALL have port BpAddr, input, 32, breakpoint PC.
REQ-008 SHALL have port PcCurrent, input, 32, current PC of the core.
REQ-009 SHALL have port CoreEn, output, 1, core advances one instruction this cycle.
REQ-010 SHALL have port State, output, 2, FSM state: 00 HALT, 01 RUN, 10 STEP.
REQ-011 SHALL have port HaltCause, output, 2, reason for last HALT entry: 00 NONE/CMD, 01 BREAKPOINT, 10 LOOP, 11 STEP_DONE.
REQ-012 SHALL have port CycleCnt, output, 32, cycles since reset release.
REQ-013 SHALL have port RetireCnt, output, 32, cycles with CoreEn=1 since reset release.

Function
REQ-014 SHALL implement states HALT, RUN, STEP as registered state; State mirrors the register.
REQ-015 In HALT, SHALL drive CoreEn=0 and CmdReady=1; accepted RUN -> RUN, accepted STEP -> STEP, accepted NOP/HALT -> stay.
REQ-016 In RUN, SHALL drive CmdReady=1 and CoreEn=1 unless a halt condition (REQ-018..020) holds this cycle, in which case CoreEn=0 in the same cycle and next state is HALT.
REQ-017 In STEP, SHALL drive CmdReady=0 and CoreEn=1 for exactly one cycle, then enter HALT with HaltCause=STEP_DONE; breakpoint and loop checks are ignored in STEP.
REQ-018 Accepted HALT cmd in RUN SHALL halt with HaltCause=NONE/CMD.
REQ-019 Breakpoint hit = BpEn && PcCurrent==BpAddr && !BpSkip; in RUN it SHALL halt with HaltCause=BREAKPOINT.
REQ-020 Loop hit = PrevEn && PcCurrent==PcPrev, where PcPrev/PrevEn are PcCurrent/CoreEn registered last cycle; in RUN it SHALL halt with HaltCause=LOOP.
REQ-021 Simultaneous halt conditions: cause priority SHALL be CMD > BREAKPOINT > LOOP; accepted RUN/STEP in RUN SHALL be treated as NOP.
REQ-022 BpSkip SHALL be set on every HALT->RUN or HALT->STEP transition and cleared after the first cycle with CoreEn=1, so resuming from a breakpoint executes that instruction.
REQ-023 HaltCause SHALL update only on entry to HALT and hold otherwise; RUN/STEP entry leaves it unchanged.
REQ-024 CoreEn SHALL first assert the cycle after RUN/STEP acceptance (one-cycle latency).
REQ-025 CycleCnt SHALL increment every cycle Reset=1; RetireCnt SHALL increment every cycle CoreEn=1; both wrap 0xFFFFFFFF -> 0.

Reset
REQ-026 While Reset=0, SHALL force State=HALT, HaltCause=00, CycleCnt=0, RetireCnt=0, PcPrev=0, PrevEn=0, BpSkip=0, CoreEn=0, CmdReady=0.
REQ-027 Reset during RUN or STEP SHALL abandon the operation; no STEP_DONE cause is recorded.
REQ-028 Commands offered during reset SHALL be dropped; CmdReady=1 first in the cycle after Reset rises.

Structure
REQ-029 Shared package core_run_ctrl_pkg SHALL hold enums for Cmd codes, state encoding and halt-cause encoding, plus the 32-bit counter width constant.
REQ-030 SHALL instantiate sub-module wrap_counter (parameterised width, sync active-low clear, increment enable) twice, for CycleCnt and RetireCnt.
REQ-031 Halt-condition evaluation and CoreEn SHALL be combinational from registered state and inputs; all other outputs SHALL be registered.

Verification
REQ-032 Reset low 3 cycles, then high; RUN at cycle 1 -> CoreEn=1 from cycle 2, CycleCnt=RetireCnt+2 thereafter.
REQ-033 BpEn=1, BpAddr=0x10, PC advancing by 4 from 0 -> CoreEn=0 when PcCurrent=0x10, HaltCause=01, RetireCnt=4; RUN again -> PC advances past 0x10.
REQ-034 PC held at 0x20 in RUN -> halt one cycle after the repeat, HaltCause=10.
REQ-035 STEP from HALT -> exactly one CoreEn pulse, CmdReady=0 for that cycle, HaltCause=11, RetireCnt+1.
REQ-036 HALT cmd in the same cycle as breakpoint hit -> HaltCause=00, CoreEn=0 in that cycle.
REQ-037 Force CycleCnt to 0xFFFFFFFF -> next cycle reads 0; Reset=0 mid-STEP -> State=HALT, HaltCause=00.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_run_ctrl_pkg : shared encodings for the core run controller.  Rev 1.0
// ---------------------------------------------------------------------------
package core_run_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_HALT = 2'b10,
    CMD_STEP = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    HC_CMD        = 2'b00,
    HC_BREAKPOINT = 2'b01,
    HC_LOOP       = 2'b10,
    HC_STEP_DONE  = 2'b11
  } halt_cause_e;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrap_counter : free-wrapping up-counter with sync active-low clear.  Rev 1.0
// ---------------------------------------------------------------------------
module wrap_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_run_ctrl : debug run/halt/step controller with breakpoint and loop
//                 detection plus cycle/retire counters.  Rev 1.0
// ---------------------------------------------------------------------------
module core_run_ctrl
  import core_run_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       Cmd,
  input  logic             BpEn,
  input  logic [31:0]      BpAddr,
  input  logic [31:0]      PcCurrent,
  output logic             CoreEn,
  output logic [1:0]       State,
  output logic [1:0]       HaltCause,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] RetireCnt
);

  state_e      state_q;
  halt_cause_e cause_q;
  logic        cmd_ready_q;
  logic [31:0] pc_prev;
  logic        prev_en;
  logic        bp_skip;

  logic        accept;
  cmd_e        cmd;
  logic        cmd_halt;
  logic        bp_hit;
  logic        loop_hit;
  logic        halt_cond;
  logic        core_en;

  assign cmd       = cmd_e'(Cmd);
  assign accept    = CmdValid && cmd_ready_q;
  assign cmd_halt  = accept && (cmd == CMD_HALT);
  assign bp_hit    = BpEn && (PcCurrent == BpAddr) && !bp_skip;
  assign loop_hit  = prev_en && (PcCurrent == pc_prev);
  assign halt_cond = cmd_halt || bp_hit || loop_hit;

  // Reset gates CoreEn immediately, before the state register catches up.
  assign core_en = Reset &&
                   (((state_q == ST_RUN) && !halt_cond) || (state_q == ST_STEP));

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= ST_HALT;
      cause_q     <= HC_CMD;
      cmd_ready_q <= 1'b0;
      pc_prev     <= '0;
      prev_en     <= 1'b0;
      bp_skip     <= 1'b0;
    end else begin
      pc_prev     <= PcCurrent;
      prev_en     <= core_en;
      cmd_ready_q <= 1'b1;
      if (core_en) begin
        bp_skip <= 1'b0;
      end
      case (state_q)
        ST_HALT: begin
          // Skip arms on resume so a breakpointed instruction can execute.
          if (accept && (cmd == CMD_RUN)) begin
            state_q <= ST_RUN;
            bp_skip <= 1'b1;
          end else if (accept && (cmd == CMD_STEP)) begin
            state_q     <= ST_STEP;
            bp_skip     <= 1'b1;
            cmd_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_cond) begin
            state_q <= ST_HALT;
            if (cmd_halt) begin
              cause_q <= HC_CMD;
            end else if (bp_hit) begin
              cause_q <= HC_BREAKPOINT;
            end else begin
              cause_q <= HC_LOOP;
            end
          end
        end
        ST_STEP: begin
          state_q <= ST_HALT;
          cause_q <= HC_STEP_DONE;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign CmdReady  = cmd_ready_q;
  assign CoreEn    = core_en;
  assign State     = state_q;
  assign HaltCause = cause_q;

  wrap_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (CLK),
    .clr_n (Reset),
    .en    (1'b1),
    .count (CycleCnt)
  );

  wrap_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clk   (CLK),
    .clr_n (Reset),
    .en    (core_en),
    .count (RetireCnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_core_run_ctrl : directed self-checking bench for core_run_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_core_run_ctrl;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        core_en;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  int n_checks;
  int n_fail;
  bit track_pc;

  core_run_ctrl dut (
    .CLK       (clk),
    .Reset     (reset),
    .CmdValid  (cmd_valid),
    .CmdReady  (cmd_ready),
    .Cmd       (cmd),
    .BpEn      (bp_en),
    .BpAddr    (bp_addr),
    .PcCurrent (pc),
    .CoreEn    (core_en),
    .State     (state),
    .HaltCause (halt_cause),
    .CycleCnt  (cycle_cnt),
    .RetireCnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; the modelled core moves its PC on a retired instruction.
  task automatic cyc();
    logic en;
    @(negedge clk);
    en = core_en;
    @(posedge clk);
    #1;
    if (en && track_pc) pc = pc + 32'd4;
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    cyc();
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    track_pc  = 1'b1;
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    bp_en     = 1'b0;
    bp_addr   = 32'h0;
    pc        = 32'h0;

    // Reset with a RUN offered throughout: must be dropped.
    repeat (3) cyc();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_core_en", {31'd0, core_en}, 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_cause", {30'd0, halt_cause}, 32'd0);

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    #1;
    check("c0_ready", {31'd0, cmd_ready}, 32'd0);
    cyc();
    check("c1_ready", {31'd0, cmd_ready}, 32'd1);
    check("c1_state", {30'd0, state}, 32'd0);
    check("c1_cycle", cycle_cnt, 32'd1);

    // RUN at cycle 1 -> CoreEn from cycle 2.
    send(2'b01);
    check("c2_state", {30'd0, state}, 32'd1);
    check("c2_core_en", {31'd0, core_en}, 32'd1);
    check("c2_cycle", cycle_cnt, 32'd2);
    check("c2_retire", retire_cnt, 32'd0);
    repeat (5) cyc();
    check("run_cycle", cycle_cnt, 32'd7);
    check("run_retire", retire_cnt, 32'd5);
    check("run_gap", cycle_cnt - retire_cnt, 32'd2);

    cmd_valid = 1'b1;
    cmd       = 2'b10;
    #1;
    check("halt_core_en", {31'd0, core_en}, 32'd0);
    cyc();
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    #1;
    check("halt_state", {30'd0, state}, 32'd0);
    check("halt_cause", {30'd0, halt_cause}, 32'd0);
    check("halt_retire", retire_cnt, 32'd5);

    // Breakpoint at 0x10, PC from 0.
    pc      = 32'h0;
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    do_reset();
    send(2'b01);
    repeat (4) cyc();
    check("bp_pc_core_en", {31'd0, core_en}, 32'd0);
    check("bp_pre_state", {30'd0, state}, 32'd1);
    cyc();
    check("bp_state", {30'd0, state}, 32'd0);
    check("bp_cause", {30'd0, halt_cause}, 32'd1);
    check("bp_retire", retire_cnt, 32'd4);
    send(2'b01);
    check("bp_resume_en", {31'd0, core_en}, 32'd1);
    cyc();
    check("bp_resume_state", {30'd0, state}, 32'd1);
    check("bp_resume_retire", retire_cnt, 32'd5);
    send(2'b10);
    check("bp_cmd_halt_state", {30'd0, state}, 32'd0);

    // PC stuck at 0x20 -> loop halt.
    bp_en    = 1'b0;
    track_pc = 1'b0;
    pc       = 32'h20;
    send(2'b01);
    check("loop_first_en", {31'd0, core_en}, 32'd1);
    cyc();
    check("loop_hit_en", {31'd0, core_en}, 32'd0);
    check("loop_hit_state", {30'd0, state}, 32'd1);
    cyc();
    check("loop_state", {30'd0, state}, 32'd0);
    check("loop_cause", {30'd0, halt_cause}, 32'd2);
    check("loop_retire", retire_cnt, 32'd6);

    // Single step.
    track_pc = 1'b1;
    pc       = 32'h40;
    send(2'b11);
    check("step_state", {30'd0, state}, 32'd2);
    check("step_ready", {31'd0, cmd_ready}, 32'd0);
    check("step_core_en", {31'd0, core_en}, 32'd1);
    cyc();
    check("step_done_state", {30'd0, state}, 32'd0);
    check("step_done_cause", {30'd0, halt_cause}, 32'd3);
    check("step_done_retire", retire_cnt, 32'd7);
    check("step_done_ready", {31'd0, cmd_ready}, 32'd1);
    check("step_done_en", {31'd0, core_en}, 32'd0);

    // HALT command coinciding with a breakpoint hit.
    bp_en   = 1'b1;
    bp_addr = 32'h4C;
    send(2'b01);
    repeat (2) cyc();
    cmd_valid = 1'b1;
    cmd       = 2'b10;
    #1;
    check("prio_core_en", {31'd0, core_en}, 32'd0);
    cyc();
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    #1;
    check("prio_state", {30'd0, state}, 32'd0);
    check("prio_cause", {30'd0, halt_cause}, 32'd0);
    check("prio_retire", retire_cnt, 32'd9);

    // Cycle counter wrap.
    bp_en = 1'b0;
    force dut.u_cycle_cnt.count = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap_forced", cycle_cnt, 32'hFFFF_FFFF);
    release dut.u_cycle_cnt.count;
    @(posedge clk);
    #2;
    check("wrap_zero", cycle_cnt, 32'd0);

    // Reset in the middle of a STEP.
    send(2'b11);
    cyc();
    check("pre_rst_cause", {30'd0, halt_cause}, 32'd3);
    send(2'b11);
    check("mid_step_state", {30'd0, state}, 32'd2);
    reset = 1'b0;
    #1;
    check("mid_step_rst_en", {31'd0, core_en}, 32'd0);
    cyc();
    check("mid_step_rst_state", {30'd0, state}, 32'd0);
    check("mid_step_rst_cause", {30'd0, halt_cause}, 32'd0);
    check("mid_step_rst_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    cyc();
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_cycle", cycle_cnt, 32'd1);
    check("post_rst_retire", retire_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
